qpn_alloc_pool: RTL and testbench
=================================

Name: qpn_alloc_pool

Overview:
- Parametrised successor of the connection manager's local-QPN free list.
- Hands out free local QP numbers on open requests and takes them back on QP close.
- Adds over the previous generation:
  - configurable base, width and non-power-of-two depth
  - sequential post-reset initialisation
  - in-use bitmap that rejects out-of-range and double frees
  - free-count output
- Sits between the QP close path (free input) and the QP open/connection-request path (allocate output).

Parameters:
- MAX_QUEUE_PAIRS, 4, number of QPNs in the pool; any integer >= 2, power of two not required.
- QPN_BASE, 256, first QPN; the pool is QPN_BASE .. QPN_BASE+MAX_QUEUE_PAIRS-1.
- QPN_WIDTH, 24, QPN bit width; QPN_BASE+MAX_QUEUE_PAIRS-1 must fit.
- IDX_W (localparam), $clog2(MAX_QUEUE_PAIRS), index width.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous reset, active low
- s_qpn_fifo_valid  in  1  free request valid
- s_qpn_fifo_ready  out  1  free request ready
- s_qpn  in  QPN_WIDTH  QPN being released
- m_qpn_fifo_valid  out  1  allocated QPN valid
- m_qpn_fifo_ready  in  1  consumer takes QPN
- m_qpn  out  QPN_WIDTH  allocated QPN
- init_done  out  1  pool initialised
- free_count  out  IDX_W+1  QPNs not in use (FIFO entries + output register)
- err_invalid_free  out  1  one-cycle pulse: a free was rejected
- err_qpn  out  QPN_WIDTH  QPN of the last rejected free

Behaviour:
Reset (async assert, sync release) sets:
- state=INIT, ptrs=0, count=0, bitmap all 0, init index=0
- all outputs 0

Reset mid-operation aborts everything:
- output register and any pending free are discarded
- re-initialisation starts on release

FSM:
- INIT: one memory write per cycle, mem[i] = QPN_BASE+i, i = 0..MAX_QUEUE_PAIRS-1.
  - After MAX_QUEUE_PAIRS cycles: wr_ptr=0 (wrapped), count=MAX_QUEUE_PAIRS, go to RUN.
  - s_qpn_fifo_ready=0 and m_qpn_fifo_valid=0 throughout INIT.
- RUN: init_done=1, registered, first asserted the cycle after the last init write. No exit except reset.

Pointers:
- Range 0..MAX_QUEUE_PAIRS-1; explicit wrap to 0 after MAX_QUEUE_PAIRS-1.
- Full/empty derived from an occupancy counter, not pointer MSBs.

Allocate path:
- Registered output stage.
- In RUN, when the FIFO is non-empty and (!m_qpn_fifo_valid || m_qpn_fifo_ready):
  - pop into m_qpn
  - m_qpn_fifo_valid=1 next cycle
- FIFO empty while the output is consumed or idle: m_qpn_fifo_valid drops to 0.
- m_qpn stable while valid && !ready.
- On an m handshake: set bitmap[m_qpn-QPN_BASE].

Free path:
- s_qpn_fifo_ready = RUN && FIFO not full, registered.
- On a handshake, a free is valid iff:
  - QPN_BASE <= s_qpn <= QPN_BASE+MAX_QUEUE_PAIRS-1, and
  - its bitmap bit is 1
- Valid free, committed the next cycle:
  - write to mem[wr_ptr], clear the bitmap bit, increment wr_ptr
  - the QPN is allocatable the cycle after it is written
- Invalid free: dropped; err_invalid_free pulses the next cycle; err_qpn captures s_qpn.
- A QPN currently in the output register is not in use; freeing it is a double free and is rejected.

Simultaneous events:
- Free commit and pop in the same cycle: occupancy unchanged, free_count unchanged.
- Allocate and free handshakes in the same cycle: bitmap set and clear act on their own bits.
  - Same bit: the free is checked against the pre-set value, so it is rejected.

free_count:
- Equals FIFO occupancy + m_qpn_fifo_valid.
- Decrements only on an m handshake; increments only on a valid free commit.
- Never exceeds MAX_QUEUE_PAIRS.

Optional Feature:
- Macro: QPN_ALLOC_STATS_EN.
- Defined: adds outputs stat_alloc_cnt, stat_free_cnt and stat_err_cnt, each 32 bits.
  - They count m handshakes, valid frees and rejected frees.
  - They saturate at 2^32-1 and reset to 0 on rst_n.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Default params; release rst_n -> init_done rises after 4 init cycles (+1). With m_qpn_fifo_ready=1, m_qpn gives 256, 257, 258, 259 on consecutive cycles, then m_qpn_fifo_valid=0 and free_count=0.
- After draining, free 258 -> no error; m_qpn=258 and valid within 3 cycles; free_count goes 0->1->0 after the handshake.
- Free 258 twice with no reallocation in between -> second free gives err_invalid_free pulse and err_qpn=258; free_count unaffected.
- Free 255 and 260 -> two error pulses with err_qpn=255 and err_qpn=260; FIFO unchanged.
- MAX_QUEUE_PAIRS=5, QPN_BASE=1000: allocate all 5 (1000..1004), free in order 1003, 1000, 1004, 1001, 1002, repeat twice -> allocation order matches free order across the pointer wrap; no error.
- Hold m_qpn_fifo_ready=0 and assert rst_n low mid-run with 2 QPNs in use -> all outputs 0 immediately; after release, the full re-init sequence 256..259 appears again.

Source files
------------

// File: rtl/qpn_alloc_pool.sv
// Free list of local QP numbers: allocates QPNs from a circular FIFO, takes back closed ones.
// Latency: a QPN freed in cycle t can be presented on m_qpn at t+2. init_done rises MAX_QUEUE_PAIRS+1 cycles after reset.
// Backpressure: registered valid/ready on both sides. Optional stats counters under QPN_ALLOC_STATS_EN.
module qpn_alloc_pool #(
    parameter int MAX_QUEUE_PAIRS = 4,
    parameter int QPN_BASE        = 256,
    parameter int QPN_WIDTH       = 24
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_qpn_fifo_valid,
    output logic                               s_qpn_fifo_ready,
    input  logic [QPN_WIDTH-1:0]               s_qpn,
    output logic                               m_qpn_fifo_valid,
    input  logic                               m_qpn_fifo_ready,
    output logic [QPN_WIDTH-1:0]               m_qpn,
    output logic                               init_done,
    output logic [$clog2(MAX_QUEUE_PAIRS):0]   free_count,
    output logic                               err_invalid_free,
    output logic [QPN_WIDTH-1:0]               err_qpn
`ifdef QPN_ALLOC_STATS_EN
    ,
    output logic [31:0]                        stat_alloc_cnt,
    output logic [31:0]                        stat_free_cnt,
    output logic [31:0]                        stat_err_cnt
`endif
);

    localparam int IDX_W = $clog2(MAX_QUEUE_PAIRS);
    localparam logic [QPN_WIDTH-1:0] QPN_FIRST = QPN_WIDTH'(QPN_BASE);
    localparam logic [QPN_WIDTH-1:0] QPN_LAST  = QPN_WIDTH'(QPN_BASE + MAX_QUEUE_PAIRS - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(MAX_QUEUE_PAIRS - 1);
    localparam logic [IDX_W:0]       CNT_MAX   = (IDX_W+1)'(MAX_QUEUE_PAIRS);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state, state_nxt;
    logic [QPN_WIDTH-1:0]   mem [MAX_QUEUE_PAIRS];
    logic [IDX_W-1:0]       wr_ptr, rd_ptr, init_idx;
    logic [IDX_W:0]         count, count_nxt;
    logic [MAX_QUEUE_PAIRS-1:0] bitmap;

    logic                   s_hs, m_hs, in_range, free_ok, push, pop;
    logic [IDX_W-1:0]       s_idx, m_idx;
    logic                   mem_we;
    logic [IDX_W-1:0]       mem_waddr;
    logic [QPN_WIDTH-1:0]   mem_wdata;

    assign s_hs     = s_qpn_fifo_valid && s_qpn_fifo_ready;
    assign m_hs     = m_qpn_fifo_valid && m_qpn_fifo_ready;
    assign in_range = (s_qpn >= QPN_FIRST) && (s_qpn <= QPN_LAST);
    assign s_idx    = IDX_W'(s_qpn - QPN_FIRST);
    assign m_idx    = IDX_W'(m_qpn - QPN_FIRST);
    // A QPN sitting in the output register has its bit clear, so freeing it is rejected here.
    assign free_ok  = in_range && bitmap[s_idx];
    assign push     = s_hs && free_ok;
    assign pop      = (state == ST_RUN) && (count != '0) &&
                      (!m_qpn_fifo_valid || m_qpn_fifo_ready);

    assign free_count = count + {{IDX_W{1'b0}}, m_qpn_fifo_valid};

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr;
        mem_wdata = s_qpn;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_idx;
            mem_wdata = QPN_FIRST + QPN_WIDTH'(init_idx);
            if (init_idx == IDX_LAST) begin
                state_nxt = ST_RUN;
                count_nxt = CNT_MAX;
            end
        end else begin
            mem_we = push;
            case ({push, pop})
                2'b10:   count_nxt = count + {{IDX_W{1'b0}}, 1'b1};
                2'b01:   count_nxt = count - {{IDX_W{1'b0}}, 1'b1};
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_INIT;
            init_idx         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bitmap           <= '0;
            m_qpn_fifo_valid <= 1'b0;
            m_qpn            <= '0;
            s_qpn_fifo_ready <= 1'b0;
            init_done        <= 1'b0;
            err_invalid_free <= 1'b0;
            err_qpn          <= '0;
        end else begin
            state            <= state_nxt;
            count            <= count_nxt;
            init_done        <= (state_nxt == ST_RUN);
            s_qpn_fifo_ready <= (state_nxt == ST_RUN) && (count_nxt < CNT_MAX);

            if (state == ST_INIT) begin
                init_idx <= (init_idx == IDX_LAST) ? '0 : init_idx + 1'b1;
            end

            if (push) begin
                wr_ptr <= (wr_ptr == IDX_LAST) ? '0 : wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr           <= (rd_ptr == IDX_LAST) ? '0 : rd_ptr + 1'b1;
                m_qpn            <= mem[rd_ptr];
                m_qpn_fifo_valid <= 1'b1;
            end else if (m_hs) begin
                m_qpn_fifo_valid <= 1'b0;
            end

            // Set and clear never hit the same bit in one cycle: a free of the
            // QPN being handed out sees its bit still clear and is rejected.
            if (m_hs) begin
                bitmap[m_idx] <= 1'b1;
            end
            if (push) begin
                bitmap[s_idx] <= 1'b0;
            end

            err_invalid_free <= s_hs && !free_ok;
            if (s_hs && !free_ok) begin
                err_qpn <= s_qpn;
            end
        end
    end

`ifdef QPN_ALLOC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_cnt <= '0;
            stat_free_cnt  <= '0;
            stat_err_cnt   <= '0;
        end else begin
            if (m_hs && (stat_alloc_cnt != '1)) begin
                stat_alloc_cnt <= stat_alloc_cnt + 1'b1;
            end
            if (push && (stat_free_cnt != '1)) begin
                stat_free_cnt <= stat_free_cnt + 1'b1;
            end
            if (s_hs && !free_ok && (stat_err_cnt != '1)) begin
                stat_err_cnt <= stat_err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qpn_alloc_pool.sv
// Directed bench for qpn_alloc_pool: a cycle table on the default pool plus
// sequences for mid-run reset and a 5-entry pool with pointer wrap.
module tb_qpn_alloc_pool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance: MAX_QUEUE_PAIRS=4, QPN_BASE=256
    logic        rst0_n, sv0, sr0, mv0, mr0, done0, err0;
    logic [23:0] sq0, mq0, eq0;
    logic [2:0]  fc0;

    // second instance: MAX_QUEUE_PAIRS=5, QPN_BASE=1000
    logic        rst1_n, sv1, sr1, mv1, mr1, done1, err1;
    logic [23:0] sq1, mq1, eq1;
    logic [3:0]  fc1;

`ifdef QPN_ALLOC_STATS_EN
    logic [31:0] sa0, sf0, se0, sa1, sf1, se1;
`endif

    qpn_alloc_pool dut0 (
        .clk(clk), .rst_n(rst0_n),
        .s_qpn_fifo_valid(sv0), .s_qpn_fifo_ready(sr0), .s_qpn(sq0),
        .m_qpn_fifo_valid(mv0), .m_qpn_fifo_ready(mr0), .m_qpn(mq0),
        .init_done(done0), .free_count(fc0),
        .err_invalid_free(err0), .err_qpn(eq0)
`ifdef QPN_ALLOC_STATS_EN
        , .stat_alloc_cnt(sa0), .stat_free_cnt(sf0), .stat_err_cnt(se0)
`endif
    );

    qpn_alloc_pool #(.MAX_QUEUE_PAIRS(5), .QPN_BASE(1000), .QPN_WIDTH(24)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .s_qpn_fifo_valid(sv1), .s_qpn_fifo_ready(sr1), .s_qpn(sq1),
        .m_qpn_fifo_valid(mv1), .m_qpn_fifo_ready(mr1), .m_qpn(mq1),
        .init_done(done1), .free_count(fc1),
        .err_invalid_free(err1), .err_qpn(eq1)
`ifdef QPN_ALLOC_STATS_EN
        , .stat_alloc_cnt(sa1), .stat_free_cnt(sf1), .stat_err_cnt(se1)
`endif
    );

    typedef struct {
        logic        sv;
        logic [23:0] sq;
        logic        mr;
        logic        mv;
        logic [23:0] mq;
        logic [2:0]  fc;
        logic        err;
        logic [23:0] eq;
        logic        done;
        logic        sr;
    } vec_t;

    vec_t tbl [24];
    int   vecs = 0;
    int   errs = 0;
    int   err_pulses1 = 0;
    int   order [5] = '{1003, 1000, 1004, 1001, 1002};

    always @(negedge clk) begin
        if (rst1_n && err1) err_pulses1++;
    end

    task automatic setv(input int k, input int sv, input int sq, input int mr,
                        input int mv, input int mq, input int fc,
                        input int err, input int eq, input int done, input int sr);
        tbl[k].sv   = sv[0];
        tbl[k].sq   = sq[23:0];
        tbl[k].mr   = mr[0];
        tbl[k].mv   = mv[0];
        tbl[k].mq   = mq[23:0];
        tbl[k].fc   = fc[2:0];
        tbl[k].err  = err[0];
        tbl[k].eq   = eq[23:0];
        tbl[k].done = done[0];
        tbl[k].sr   = sr[0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input int k);
        vec_t v;
        logic ok;
        v  = tbl[k];
        ok = (mv0 === v.mv) && (!v.mv || (mq0 === v.mq)) && (fc0 === v.fc) &&
             (err0 === v.err) && (eq0 === v.eq) && (done0 === v.done) && (sr0 === v.sr);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL vec%0d: got mv=%0d mq=%0d fc=%0d err=%0d eq=%0d done=%0d sr=%0d, expected mv=%0d mq=%0d fc=%0d err=%0d eq=%0d done=%0d sr=%0d",
                     k, mv0, mq0, fc0, err0, eq0, done0, sr0,
                     v.mv, v.mq, v.fc, v.err, v.eq, v.done, v.sr);
        end
    endtask

    task automatic chk_zero0(input string name);
        check({name, "_flags"}, {27'd0, mv0, sr0, done0, err0, |fc0}, 32'd0);
        check({name, "_m_qpn"}, {8'd0, mq0}, 32'd0);
        check({name, "_err_qpn"}, {8'd0, eq0}, 32'd0);
    endtask

    task automatic free1(input int q);
        int n = 0;
        @(negedge clk);
        sv1 = 1'b1;
        sq1 = q[23:0];
        while (!sr1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sr1) begin
            vecs++; errs++;
            $display("FAIL free1_timeout: s_qpn_fifo_ready=0 for qpn %0d, required 1", q);
        end
        @(posedge clk);
        #1 sv1 = 1'b0;
    endtask

    task automatic take1(output int q);
        int n = 0;
        @(negedge clk);
        mr1 = 1'b1;
        while (!mv1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mv1) begin
            vecs++; errs++;
            $display("FAIL take1_timeout: m_qpn_fifo_valid=0, required 1");
            q = -1;
        end else begin
            q = int'(mq1);
        end
        @(posedge clk);
        #1 mr1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int q;

        //   k  sv  sq   mr | mv  mq  fc err eq  done sr
        setv( 0, 0,   0, 0,   0,   0, 0, 0,   0, 0, 0);
        setv( 1, 0,   0, 0,   0,   0, 0, 0,   0, 0, 0);
        setv( 2, 0,   0, 0,   0,   0, 0, 0,   0, 0, 0);
        setv( 3, 0,   0, 0,   0,   0, 4, 0,   0, 1, 0);
        setv( 4, 0,   0, 1,   1, 256, 4, 0,   0, 1, 1);
        setv( 5, 0,   0, 1,   1, 257, 3, 0,   0, 1, 1);
        setv( 6, 0,   0, 1,   1, 258, 2, 0,   0, 1, 1);
        setv( 7, 0,   0, 1,   1, 259, 1, 0,   0, 1, 1);
        setv( 8, 1, 258, 1,   0,   0, 0, 0,   0, 1, 1);
        setv( 9, 0,   0, 1,   0,   0, 1, 0,   0, 1, 1);
        setv(10, 0,   0, 1,   1, 258, 1, 0,   0, 1, 1);
        setv(11, 1, 258, 0,   0,   0, 0, 0,   0, 1, 1);
        setv(12, 1, 258, 0,   0,   0, 1, 0,   0, 1, 1);
        setv(13, 1, 255, 0,   1, 258, 1, 1, 258, 1, 1);
        setv(14, 1, 260, 0,   1, 258, 1, 1, 255, 1, 1);
        setv(15, 0,   0, 0,   1, 258, 1, 1, 260, 1, 1);
        setv(16, 1, 258, 0,   1, 258, 1, 0, 260, 1, 1);
        setv(17, 1, 258, 1,   1, 258, 1, 1, 258, 1, 1);
        setv(18, 1, 258, 1,   0,   0, 0, 1, 258, 1, 1);
        setv(19, 0,   0, 1,   0,   0, 1, 0, 258, 1, 1);
        setv(20, 1, 256, 1,   1, 258, 1, 0, 258, 1, 1);
        setv(21, 1, 257, 1,   0,   0, 1, 0, 258, 1, 1);
        setv(22, 0,   0, 0,   1, 256, 2, 0, 258, 1, 1);
        setv(23, 0,   0, 0,   1, 256, 2, 0, 258, 1, 1);

        rst0_n = 1'b0; rst1_n = 1'b0;
        sv0 = 1'b0; sq0 = '0; mr0 = 1'b0;
        sv1 = 1'b0; sq1 = '0; mr1 = 1'b0;
        #12;
        chk_zero0("reset");
        @(negedge clk);
        rst0_n = 1'b1; rst1_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk_vec(k);
            sv0 = tbl[k].sv;
            sq0 = tbl[k].sq;
            mr0 = tbl[k].mr;
        end

        // Mid-run reset with 258 and 259 in use and the consumer stalled.
        @(negedge clk);
        #2 rst0_n = 1'b0;
        #1 chk_zero0("midrst");
        @(negedge clk);
        rst0_n = 1'b1;
        mr0    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 20);
        check("reinit_done_cycles", n, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reinit_m_qpn", mv0 ? {8'd0, mq0} : 32'hFFFF_FFFF, 256 + i);
        end
        @(negedge clk);
        check("reinit_drained", {28'd0, mv0, fc0}, 32'd0);
        mr0 = 1'b0;

        // Five-entry pool: drain, then free/reallocate in a fixed order across the wrap.
        for (int i = 0; i < 5; i++) begin
            take1(q);
            check("p5_init_alloc", q, 1000 + i);
        end
        @(negedge clk);
        check("p5_free_count_empty", {28'd0, fc1}, 32'd0);
        for (int rep = 0; rep < 2; rep++) begin
            for (int j = 0; j < 5; j++) free1(order[j]);
            @(negedge clk);
            check("p5_free_count_full", {28'd0, fc1}, 32'd5);
            for (int j = 0; j < 5; j++) begin
                take1(q);
                check("p5_realloc_order", q, order[j]);
            end
            @(negedge clk);
            check("p5_free_count_drained", {28'd0, fc1}, 32'd0);
        end
        check("p5_error_pulses", err_pulses1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
